ascii_hex_to_bin: RTL and testbench

Receive-side counterpart of the binary-to-ASCII-hex display path. Accepts a stream of ASCII characters one per cycle over a valid/ready handshake and assembles 2·NBYTES hex digits, most-significant first, into one NBYTES·8-bit binary word. Sits between a character source (UART receiver or command FIFO) and the processor's debug/load logic. Malformed input is flagged and discarded. A raw bypass mode passes characters through untranslated.

---
 rtl/ascii_hex_to_bin_pkg.sv | 38 +++
 rtl/ascii_hex_to_bin_from_ascii.sv | 47 ++++
 rtl/ascii_hex_to_bin.sv | 126 ++++++++++++
 tb/tb_ascii_hex_to_bin.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_hex_to_bin_pkg.sv
// ============================================================================
//  Module   : ascii_hex_to_bin_pkg
//  Desc     : Shared ASCII constants, FSM state and character-class types for
//             the ASCII-hex to binary receive path.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ascii_hex_to_bin_pkg;

    localparam logic [7:0] c_ASCII_ZERO    = 8'h30;
    localparam logic [7:0] c_ASCII_NINE    = 8'h39;
    localparam logic [7:0] c_ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] c_ASCII_UPPER_F = 8'h46;
    localparam logic [7:0] c_ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] c_ASCII_LOWER_F = 8'h66;
    localparam logic [7:0] c_ASCII_SPACE   = 8'h20;
    localparam logic [7:0] c_ASCII_CR      = 8'h0D;
    localparam logic [7:0] c_ASCII_LF      = 8'h0A;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_HOLD    = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        HEX = 2'd0,
        SEP = 2'd1,
        BAD = 2'd2
    } char_class_t;

    function automatic logic is_separator(input logic [7:0] ch);
        return (ch == c_ASCII_SPACE) || (ch == c_ASCII_CR) || (ch == c_ASCII_LF);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ascii_hex_to_bin_from_ascii.sv
// ============================================================================
//  Module   : ascii_hex_to_bin_from_ascii
//  Desc     : Classifies one ASCII byte as hex digit / separator / invalid and
//             returns its nibble. Lowercase digits decode only when
//             LOWERCASE_HEX_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_hex_to_bin_from_ascii
    import ascii_hex_to_bin_pkg::*;
(
    input  logic [7:0]  i_char,
    output logic [3:0]  o_nibble,
    output char_class_t o_class
);

    logic w_is_digit;
    logic w_is_upper;
    logic w_is_lower;

    assign w_is_digit = (i_char >= c_ASCII_ZERO)    && (i_char <= c_ASCII_NINE);
    assign w_is_upper = (i_char >= c_ASCII_UPPER_A) && (i_char <= c_ASCII_UPPER_F);
`ifdef LOWERCASE_HEX_EN
    assign w_is_lower = (i_char >= c_ASCII_LOWER_A) && (i_char <= c_ASCII_LOWER_F);
`else
    assign w_is_lower = 1'b0;
`endif

    // Digits sit at x0..x9 and letters at x1..x6, so the low nibble is enough.
    always_comb begin
        o_nibble = 4'h0;
        o_class  = BAD;
        if (w_is_digit) begin
            o_nibble = i_char[3:0];
            o_class  = HEX;
        end else if (w_is_upper || w_is_lower) begin
            o_nibble = i_char[3:0] + 4'd9;
            o_class  = HEX;
        end else if (is_separator(i_char)) begin
            o_class  = SEP;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ascii_hex_to_bin.sv
// ============================================================================
//  Module   : ascii_hex_to_bin
//  Desc     : Assembles 2*NBYTES ASCII hex digits (MS first) into a binary
//             word over valid/ready; raw bypass when enable=0. Lowercase
//             digit support selected by LOWERCASE_HEX_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ascii_hex_to_bin
    import ascii_hex_to_bin_pkg::*;
#(
    parameter int NBYTES = 1
)(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [7:0]          char_in,
    input  logic                char_valid,
    output logic                char_ready,
    output logic [8*NBYTES-1:0] data_out,
    output logic                data_valid,
    input  logic                data_ready,
    output logic                err
);

    localparam int c_DIGITS = 2 * NBYTES;
    localparam int c_WIDTH  = 8 * NBYTES;
    localparam int c_CNT_W  = $clog2(c_DIGITS + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_DIGITS - 1);

    state_t               r_state_q, w_state_d;
    logic [c_CNT_W-1:0]   r_cnt_q,   w_cnt_d;
    logic [c_WIDTH-1:0]   r_acc_q,   w_acc_d;
    logic [c_WIDTH-1:0]   r_data_q,  w_data_d;
    logic                 r_err_q,   w_err_d;

    logic [3:0]           w_nibble;
    char_class_t          w_class;
    logic [c_WIDTH-1:0]   w_shifted;

    ascii_hex_to_bin_from_ascii u_from_ascii (
        .i_char   (char_in),
        .o_nibble (w_nibble),
        .o_class  (w_class)
    );

    assign w_shifted  = {r_acc_q[c_WIDTH-5:0], w_nibble};

    assign char_ready = (r_state_q == S_COLLECT);
    assign data_valid = (r_state_q == S_HOLD);
    assign data_out   = r_data_q;
    assign err        = r_err_q;

    // A partial word only exists after hex characters, so a switch to raw mode
    // with cnt!=0 is handled by the raw branch clearing the accumulator.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_acc_d   = r_acc_q;
        w_data_d  = r_data_q;
        w_err_d   = 1'b0;

        case (r_state_q)
            S_HOLD: begin
                if (data_ready) begin
                    w_state_d = S_COLLECT;
                end
            end

            default: begin
                if (char_valid) begin
                    if (!enable) begin
                        w_data_d  = c_WIDTH'(char_in);
                        w_acc_d   = '0;
                        w_cnt_d   = '0;
                        w_state_d = S_HOLD;
                    end else begin
                        case (w_class)
                            HEX: begin
                                if (r_cnt_q == c_CNT_LAST) begin
                                    w_data_d  = w_shifted;
                                    w_acc_d   = '0;
                                    w_cnt_d   = '0;
                                    w_state_d = S_HOLD;
                                end else begin
                                    w_acc_d   = w_shifted;
                                    w_cnt_d   = r_cnt_q + 1'b1;
                                end
                            end
                            SEP: begin
                                w_err_d = (r_cnt_q != '0);
                                w_acc_d = '0;
                                w_cnt_d = '0;
                            end
                            default: begin
                                w_err_d = 1'b1;
                                w_acc_d = '0;
                                w_cnt_d = '0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= S_COLLECT;
            r_cnt_q   <= '0;
            r_acc_q   <= '0;
            r_data_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_acc_q   <= w_acc_d;
            r_data_q  <= w_data_d;
            r_err_q   <= w_err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ascii_hex_to_bin.sv
// ============================================================================
//  Module   : tb_ascii_hex_to_bin
//  Desc     : Self-checking bench; one-byte and two-byte instances share the
//             character stream and are each compared against a digit-string
//             reference model. Honours LOWERCASE_HEX_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ascii_hex_to_bin;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        data_ready;

    logic        rdy0, dv0, err0;
    logic [7:0]  do0;
    logic        rdy1, dv1, err1;
    logic [15:0] do1;

    always #5 clk = ~clk;

    ascii_hex_to_bin #(.NBYTES(1)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable), .char_in(char_in),
        .char_valid(char_valid), .char_ready(rdy0), .data_out(do0),
        .data_valid(dv0), .data_ready(data_ready), .err(err0)
    );

    ascii_hex_to_bin #(.NBYTES(2)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .char_in(char_in),
        .char_valid(char_valid), .char_ready(rdy1), .data_out(do1),
        .data_valid(dv1), .data_ready(data_ready), .err(err1)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;

    // Reference model: pending digits kept as a count plus running value.
    int          m_digits [2] = '{2, 4};
    int          m_ndig   [2];
    longint      m_val    [2];
    logic [31:0] m_data   [2];
    bit          m_valid  [2];
    bit          m_err    [2];

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
`ifdef LOWERCASE_HEX_EN
        if (c >= 8'h61 && c <= 8'h66) return int'(c) - 87;
`endif
        if (c == 8'h20 || c == 8'h0D || c == 8'h0A) return -2;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ndig[i] = 0; m_val[i] = 0; m_data[i] = 0;
            m_valid[i] = 0; m_err[i] = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [7:0] c, input bit en, input bit dr);
        for (int i = 0; i < 2; i++) begin
            bit acc;
            int k;
            acc = v && !m_valid[i];
            m_err[i] = 0;
            if (m_valid[i] && dr) m_valid[i] = 0;
            if (acc) begin
                if (!en) begin
                    m_ndig[i] = 0; m_val[i] = 0;
                    m_data[i] = {24'b0, c};
                    m_valid[i] = 1;
                end else begin
                    k = hexval(c);
                    if (k >= 0) begin
                        m_val[i] = m_val[i] * 16 + k;
                        m_ndig[i]++;
                        if (m_ndig[i] == m_digits[i]) begin
                            m_data[i] = 32'(m_val[i]);
                            m_valid[i] = 1;
                            m_ndig[i] = 0; m_val[i] = 0;
                        end
                    end else begin
                        m_err[i] = (k == -1) || (m_ndig[i] != 0);
                        m_ndig[i] = 0; m_val[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ready0", 32'(rdy0), 32'(!m_valid[0]));
        chk("valid0", 32'(dv0),  32'(m_valid[0]));
        chk("data0",  32'(do0),  m_data[0]);
        chk("err0",   32'(err0), 32'(m_err[0]));
        chk("ready1", 32'(rdy1), 32'(!m_valid[1]));
        chk("valid1", 32'(dv1),  32'(m_valid[1]));
        chk("data1",  32'(do1),  m_data[1]);
        chk("err1",   32'(err1), 32'(m_err[1]));
    endtask

    // Called at a falling edge: drive, advance one rising edge, check.
    task automatic cycle(input bit v, input logic [7:0] c, input bit en, input bit dr);
        char_valid = v; char_in = c; enable = en; data_ready = dr;
        model_step(v, c, en, dr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic send(input int who, input logic [7:0] c, input bit en);
        for (int t = 0; t < 16; t++) begin
            bit will;
            will = !m_valid[who];
            cycle(1'b1, c, en, 1'b1);
            if (will) return;
        end
        chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        char_valid = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        string pool;
        pool = "0123456789ABCDEFabcdef";
        rst = 1'b1; enable = 1'b1; char_in = 8'h00; char_valid = 1'b0; data_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all();
        rst = 1'b0;

        // '3','A' -> 0x3A the cycle after 'A'
        send(0, "3", 1'b1);
        send(0, "A", 1'b1);
        chk("d_3A_valid", 32'(dv0), 32'd1);
        chk("d_3A_data",  32'(do0), 32'h3A);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // Two-byte word held under backpressure, input ignored while holding
        do_reset();
        send(1, "1", 1'b1);
        send(1, "2", 1'b1);
        send(1, "3", 1'b1);
        send(1, "4", 1'b1);
        chk("d_1234_data", 32'(do1), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, "7", 1'b1, 1'b0);
            chk("d_1234_hold", 32'(do1), 32'h1234);
            chk("d_1234_rdy",  32'(rdy1), 32'd0);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("d_1234_taken", 32'(dv1), 32'd0);

        // Invalid character discards the partial digit
        do_reset();
        send(0, "4", 1'b1);
        send(0, "G", 1'b1);
        chk("d_G_err",   32'(err0), 32'd1);
        chk("d_G_noval", 32'(dv0),  32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        chk("d_G_pulse", 32'(err0), 32'd0);
        send(0, "1", 1'b1);
        send(0, "2", 1'b1);
        chk("d_12_data", 32'(do0), 32'h12);

        // Lowercase handling
        do_reset();
        send(0, "f", 1'b1);
`ifdef LOWERCASE_HEX_EN
        chk("d_f_noerr", 32'(err0), 32'd0);
        send(0, "f", 1'b1);
        chk("d_ff_data", 32'(do0), 32'hFF);
`else
        chk("d_f_err",   32'(err0), 32'd1);
        send(0, "f", 1'b1);
        chk("d_f_noval", 32'(dv0), 32'd0);
`endif

        // Raw bypass, then a separator with nothing pending
        do_reset();
        send(0, 8'h41, 1'b0);
        chk("d_raw_data", 32'(do0), 32'h41);
        chk("d_raw_err",  32'(err0), 32'd0);
        send(0, " ", 1'b1);
        send(0, " ", 1'b1);
        chk("d_sp_err",   32'(err0), 32'd0);
        chk("d_sp_val",   32'(dv0),  32'd0);

        // Reset mid-word
        do_reset();
        send(0, "7", 1'b1);
        do_reset();
        send(0, "8", 1'b1);
        send(0, "9", 1'b1);
        chk("d_89_data", 32'(do0), 32'h89);
        chk("d_89_err",  32'(err0), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] c;
            int sel;
            if ($urandom_range(299) == 0) begin
                do_reset();
            end else begin
                sel = int'($urandom_range(99));
                if (sel < 70)      c = pool[$urandom_range(21)];
                else if (sel < 80) c = 8'h20;
                else if (sel < 85) c = 8'h0D;
                else if (sel < 90) c = 8'h0A;
                else               c = 8'($urandom);
                cycle(($urandom_range(3) != 0), c,
                      ($urandom_range(9) != 0), ($urandom_range(3) != 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
